// File: rtl/cheshire_rst_boot_ctrl_if.sv
// Strap, request and reset/boot status signals between the sequencer and its environment.
// master drives the strap pads and reset requests; slave is the sequencer.
interface cheshire_rst_boot_ctrl_if;
  logic       test_mode_i;
  logic [1:0] boot_mode_pad_i;
  logic       sw_rst_req_i;
  logic       wdt_kick_i;
  logic       soc_rst_no;
  logic [1:0] boot_mode_o;
  logic [1:0] rst_cause_o;
  logic       busy_o;

  modport master (
    output test_mode_i, boot_mode_pad_i, sw_rst_req_i, wdt_kick_i,
    input  soc_rst_no, boot_mode_o, rst_cause_o, busy_o
  );

  modport slave (
    input  test_mode_i, boot_mode_pad_i, sw_rst_req_i, wdt_kick_i,
    output soc_rst_no, boot_mode_o, rst_cause_o, busy_o
  );
endinterface

// File: rtl/cheshire_rst_boot_ctrl.sv
// Reset/boot sequencer for the Cheshire SoC: strap sync + debounce, reset hold, SW/WDT re-boot.
// Define CHESHIRE_RST_WDT_EN to build in the RUN-state watchdog.
module cheshire_rst_boot_ctrl #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 16,
  parameter int unsigned HoldCycles     = 64,
  parameter int unsigned WdtCycles      = 2**20
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  cheshire_rst_boot_ctrl_if.slave  bus
);

  localparam int unsigned MaxDh     = (DebounceCycles > HoldCycles) ? DebounceCycles : HoldCycles;
  localparam int unsigned MaxCycles = (MaxDh > WdtCycles) ? MaxDh : WdtCycles;
  localparam int unsigned CntWidth  = $clog2(MaxCycles) + 1;

  typedef logic [CntWidth-1:0] cnt_t;

  localparam cnt_t DebLast  = cnt_t'(DebounceCycles - 1);
  localparam cnt_t HoldLast = cnt_t'(HoldCycles - 1);

  localparam logic [1:0] StReset    = 2'd0;
  localparam logic [1:0] StDebounce = 2'd1;
  localparam logic [1:0] StHold     = 2'd2;
  localparam logic [1:0] StRun      = 2'd3;

  localparam logic [1:0] CausePor = 2'b00;
  localparam logic [1:0] CauseSw  = 2'b01;

  logic [SyncStages-1:0][1:0] sync_q;
  logic [1:0]                 strap_s;

  logic [1:0] state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] cand_q, cand_d;
  logic [1:0] boot_q, boot_d;
  logic [1:0] cause_q, cause_d;
  logic       soc_rst_q, soc_rst_d;
  cnt_t       wdt_q, wdt_d;

  assign strap_s = sync_q[SyncStages-1];

`ifdef CHESHIRE_RST_WDT_EN
  localparam logic [1:0] CauseWdt = 2'b10;
  localparam cnt_t       WdtLast  = cnt_t'(WdtCycles - 1);
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = bus.wdt_kick_i;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    boot_d    = boot_q;
    cause_d   = cause_q;
    soc_rst_d = soc_rst_q;
    // Watchdog only runs while the SoC is out of reset.
    wdt_d     = '0;
    unique case (state_q)
      StReset: begin
        state_d = StDebounce;
        cnt_d   = '0;
      end
      StDebounce: begin
        if (strap_s != cand_q) begin
          cand_d = strap_s;
          cnt_d  = '0;
        end else if (cnt_q == DebLast) begin
          boot_d  = cand_q;
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d     = '0;
          soc_rst_d = 1'b1;
          state_d   = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        soc_rst_d = 1'b1;
`ifdef CHESHIRE_RST_WDT_EN
        wdt_d = bus.wdt_kick_i ? '0 : wdt_q + 1'b1;
`endif
        // SW request takes priority over a coincident watchdog expiry.
        if (bus.sw_rst_req_i) begin
          soc_rst_d = 1'b0;
          cause_d   = CauseSw;
          cnt_d     = '0;
          wdt_d     = '0;
          state_d   = StDebounce;
        end
`ifdef CHESHIRE_RST_WDT_EN
        else if (!bus.wdt_kick_i && (wdt_q == WdtLast)) begin
          soc_rst_d = 1'b0;
          cause_d   = CauseWdt;
          cnt_d     = '0;
          wdt_d     = '0;
          state_d   = StDebounce;
        end
`endif
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      state_q   <= StReset;
      cnt_q     <= '0;
      cand_q    <= '0;
      boot_q    <= '0;
      cause_q   <= CausePor;
      soc_rst_q <= 1'b0;
      wdt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SyncStages-2:0], bus.boot_mode_pad_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      boot_q    <= boot_d;
      cause_q   <= cause_d;
      soc_rst_q <= soc_rst_d;
      wdt_q     <= wdt_d;
    end
  end

  // DFT bypass hands reset and straps straight to the SoC without touching the FSM.
  assign bus.soc_rst_no  = bus.test_mode_i ? rst_ni : soc_rst_q;
  assign bus.boot_mode_o = bus.test_mode_i ? bus.boot_mode_pad_i : boot_q;
  assign bus.rst_cause_o = cause_q;
  assign bus.busy_o      = (state_q != StRun);

endmodule
